// File: rtl/plcp_header_decode.sv
// 802.11b PLCP header decoder: collects the 48-bit header after SFD,
// checks CRC-16 and field legality, publishes rate/service/length.
module plcp_header_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_bit,
    input  logic        data_bit_valid,
    input  logic        sfd_detected,
    output logic [7:0]  pkt_rate,
    output logic [7:0]  pkt_service,
    output logic [15:0] pkt_len,
    output logic        pkt_header_valid,
    output logic        pkt_header_valid_strobe,
    output logic        pkt_header_error_strobe
);

    typedef enum logic [2:0] {IDLE, HDR, CHECK, PAYLOAD, HOLD} state_t;

    state_t      state_q, state_d;
    logic [47:0] hdr_q, hdr_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  rate_q, rate_d;
    logic [7:0]  svc_q, svc_d;
    logic [15:0] len_q, len_d;
    logic        vld_q, vld_d;
    logic        vstb_q, vstb_d;
    logic        estb_q, estb_d;

    logic [7:0]  sig;
    logic [15:0] hlen;
    logic [15:0] crc_rx;
    logic [15:0] crc_step;
    logic [15:0] cnt_inc;
    logic        fb;
    logic        rate_ok;
    logic        accept;

    assign sig     = hdr_q[7:0];
    assign hlen    = hdr_q[31:16];
    assign cnt_inc = cnt_q + 16'd1;
    assign fb      = crc_q[15] ^ data_bit;
    assign crc_step = {crc_q[14:0], 1'b0} ^ ({16{fb}} & 16'h1021);

    // The CRC field arrives MSB-first, so bit 32 of the shift register is x^15.
    always_comb begin
        crc_rx = '0;
        for (int k = 0; k < 16; k++) begin
            crc_rx[15-k] = hdr_q[32+k];
        end
    end

    assign rate_ok = (sig == 8'h0A) || (sig == 8'h14) ||
                     (sig == 8'h37) || (sig == 8'h6E);
    assign accept  = (crc_rx == ~crc_q) && rate_ok && (hlen >= 16'd32) &&
                     ((sig != 8'h0A) || (hlen[2:0] == 3'd0));

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        rate_d  = rate_q;
        svc_d   = svc_q;
        len_d   = len_q;
        vld_d   = vld_q;
        vstb_d  = 1'b0;
        estb_d  = 1'b0;
        if (sfd_detected) begin
            rate_d  = '0;
            svc_d   = '0;
            len_d   = '0;
            vld_d   = 1'b0;
            cnt_d   = '0;
            crc_d   = 16'hFFFF;
            state_d = HDR;
        end else begin
            unique case (state_q)
                IDLE: ;
                HDR: begin
                    if (data_bit_valid) begin
                        hdr_d = {data_bit, hdr_q[47:1]};
                        if (cnt_q < 16'd32) crc_d = crc_step;
                        cnt_d = cnt_inc;
                        if (cnt_q == 16'd47) state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        rate_d  = sig;
                        svc_d   = hdr_q[15:8];
                        len_d   = hlen;
                        vld_d   = 1'b1;
                        vstb_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = (sig == 8'h0A) ? PAYLOAD : HOLD;
                    end else begin
                        estb_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                PAYLOAD: begin
                    if (data_bit_valid) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == len_q) begin
                            rate_d  = '0;
                            svc_d   = '0;
                            len_d   = '0;
                            vld_d   = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                HOLD: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            crc_q   <= 16'hFFFF;
            cnt_q   <= '0;
            rate_q  <= '0;
            svc_q   <= '0;
            len_q   <= '0;
            vld_q   <= 1'b0;
            vstb_q  <= 1'b0;
            estb_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            rate_q  <= rate_d;
            svc_q   <= svc_d;
            len_q   <= len_d;
            vld_q   <= vld_d;
            vstb_q  <= vstb_d;
            estb_q  <= estb_d;
        end
    end

    assign pkt_rate                = rate_q;
    assign pkt_service             = svc_q;
    assign pkt_len                 = len_q;
    assign pkt_header_valid        = vld_q;
    assign pkt_header_valid_strobe = vstb_q;
    assign pkt_header_error_strobe = estb_q;

endmodule

// File: tb/tb_plcp_header_decode.sv
// Scoreboard bench for plcp_header_decode: directed headers push expected
// events, a negedge monitor pops and compares them.
module tb_plcp_header_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        data_bit = 1'b0;
    logic        data_bit_valid = 1'b0;
    logic        sfd_detected = 1'b0;
    logic [7:0]  pkt_rate;
    logic [7:0]  pkt_service;
    logic [15:0] pkt_len;
    logic        pkt_header_valid;
    logic        pkt_header_valid_strobe;
    logic        pkt_header_error_strobe;

    plcp_header_decode dut (
        .clk                     (clk),
        .reset                   (reset),
        .data_bit                (data_bit),
        .data_bit_valid          (data_bit_valid),
        .sfd_detected            (sfd_detected),
        .pkt_rate                (pkt_rate),
        .pkt_service             (pkt_service),
        .pkt_len                 (pkt_len),
        .pkt_header_valid        (pkt_header_valid),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .pkt_header_error_strobe (pkt_header_error_strobe)
    );

    always #5 clk = ~clk;

    // kind: 0 accept, 1 reject, 2 published header cleared
    typedef struct {
        int          kind;
        logic [7:0]  r;
        logic [7:0]  s;
        logic [15:0] l;
    } ev_t;

    ev_t evq[$];
    int  total = 0;
    int  bad = 0;
    bit  exp_pub = 0;
    logic prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crc16(input logic [31:0] d);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic push(input int k, input logic [7:0] r,
                        input logic [7:0] s, input logic [15:0] l);
        ev_t e;
        e.kind = k; e.r = r; e.s = s; e.l = l;
        evq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_tx(input logic b);
        data_bit = b;
        data_bit_valid = 1'b1;
        @(negedge clk);
        data_bit_valid = 1'b0;
    endtask

    task automatic sfd_pulse(input bit with_bit);
        if (exp_pub) push(2, 8'h00, 8'h00, 16'h0000);
        exp_pub = 0;
        sfd_detected = 1'b1;
        data_bit = 1'b1;
        data_bit_valid = with_bit;
        @(negedge clk);
        sfd_detected = 1'b0;
        data_bit_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic [7:0] sig, input logic [7:0] svc,
                            input logic [15:0] len, input logic [15:0] flip,
                            input bit ok, input int nbits, input bit co);
        logic [47:0] v;
        logic [15:0] rx;
        v[7:0]   = sig;
        v[15:8]  = svc;
        v[31:16] = len;
        rx = ~crc16(v[31:0]) ^ flip;
        for (int k = 0; k < 16; k++) v[32+k] = rx[15-k];
        sfd_pulse(co);
        idle(2);
        for (int i = 0; i < nbits; i++) begin
            if (i == 47) begin
                if (ok) push(0, sig, svc, len);
                else    push(1, 8'h00, 8'h00, 16'h0000);
            end
            bit_tx(v[i]);
            if (i < nbits - 1) idle(10);
        end
        if (nbits == 48) begin
            chk("strobe_early",
                {30'd0, pkt_header_valid_strobe, pkt_header_error_strobe}, 0);
            @(negedge clk);
            chk("valid_strobe_lat", {31'd0, pkt_header_valid_strobe},
                {31'd0, ok});
            chk("error_strobe_lat", {31'd0, pkt_header_error_strobe},
                {31'd0, !ok});
            exp_pub = ok;
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (pkt_header_valid_strobe && pkt_header_error_strobe)
            chk("both_strobes", 1, 0);
        if (pkt_header_valid_strobe || pkt_header_error_strobe) begin
            if (evq.size() == 0) begin
                chk("unexpected_strobe", {30'd0, pkt_header_valid_strobe,
                    pkt_header_error_strobe}, 0);
            end else begin
                e = evq.pop_front();
                chk("strobe_kind", {31'd0, pkt_header_error_strobe},
                    (e.kind == 1) ? 1 : 0);
                chk("fields", {pkt_rate, pkt_service, pkt_len},
                    {e.r, e.s, e.l});
                chk("hdr_valid_lvl", {31'd0, pkt_header_valid},
                    (e.kind == 0) ? 1 : 0);
            end
        end
        if (prev_vld && !pkt_header_valid) begin
            if (evq.size() == 0) begin
                chk("unexpected_clear", 1, 0);
            end else begin
                e = evq.pop_front();
                chk("clear_kind", e.kind, 2);
                chk("clear_fields", {pkt_rate, pkt_service, pkt_len}, 0);
            end
        end
        prev_vld = pkt_header_valid;
    end

    initial begin
        idle(3);
        chk("rst_rate", {24'd0, pkt_rate}, 0);
        chk("rst_svc", {24'd0, pkt_service}, 0);
        chk("rst_len", {16'd0, pkt_len}, 0);
        chk("rst_flags", {29'd0, pkt_header_valid, pkt_header_valid_strobe,
            pkt_header_error_strobe}, 0);
        reset = 1'b1;
        idle(3);

        send_hdr(8'h0A, 8'h04, 16'h0040, 16'h0000, 1, 48, 0);
        for (int i = 0; i < 63; i++) begin
            bit_tx(i[0]);
            idle(10);
            if (i == 62) chk("rate_pre_last", {24'd0, pkt_rate}, 32'h0A);
        end
        push(2, 8'h00, 8'h00, 16'h0000);
        exp_pub = 0;
        data_bit_valid = 1'b1;
        chk("rate_last_bit", {24'd0, pkt_rate}, 32'h0A);
        @(negedge clk);
        data_bit_valid = 1'b0;
        chk("rate_after_end", {24'd0, pkt_rate}, 0);
        chk("valid_after_end", {31'd0, pkt_header_valid}, 0);
        idle(5);

        send_hdr(8'h0A, 8'h04, 16'h0040, 16'h0020, 0, 48, 0);
        idle(3);
        chk("crc_bad_rate", {24'd0, pkt_rate}, 0);

        send_hdr(8'h37, 8'h00, 16'h0100, 16'h0000, 1, 48, 0);
        for (int i = 0; i < 300; i++) begin
            bit_tx(i[1]);
            idle(1);
        end
        chk("hold_rate", {24'd0, pkt_rate}, 32'h37);
        chk("hold_len", {16'd0, pkt_len}, 32'h0100);
        sfd_pulse(0);
        idle(1);
        chk("sfd_clears_rate", {24'd0, pkt_rate}, 0);

        send_hdr(8'h0A, 8'h00, 16'h0042, 16'h0000, 0, 48, 0);
        send_hdr(8'h0B, 8'h00, 16'h0040, 16'h0000, 0, 48, 0);

        send_hdr(8'h0A, 8'h04, 16'h0040, 16'h0000, 0, 20, 0);
        send_hdr(8'h14, 8'h00, 16'h0200, 16'h0000, 1, 48, 1);
        idle(4);

        send_hdr(8'h0A, 8'h04, 16'h0040, 16'h0000, 1, 48, 0);
        for (int i = 0; i < 10; i++) begin
            bit_tx(1'b1);
            idle(10);
        end
        push(2, 8'h00, 8'h00, 16'h0000);
        exp_pub = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_fields", {pkt_rate, pkt_service, pkt_len}, 0);
        chk("rst_mid_flags", {29'd0, pkt_header_valid,
            pkt_header_valid_strobe, pkt_header_error_strobe}, 0);
        reset = 1'b1;
        idle(3);

        send_hdr(8'h6E, 8'h80, 16'h0020, 16'h0000, 1, 48, 0);
        idle(4);
        chk("len32_rate", {24'd0, pkt_rate}, 32'h6E);
        sfd_pulse(0);
        idle(5);
        chk("queue_empty", evq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
